pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. It generalises the team's fixed-width chained adder to WIDTH bits, split into CHUNK-bit slices with one register stage per slice. The block adds a valid/ready handshake, a subtract mode and a signed-overflow flag. It sits in datapaths that need full-rate add/sub at widths where a single-cycle carry chain misses timing.

---
 rtl/pipelined_adder.sv | 108 ++++++++++
 tb/tb_pipelined_adder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Brief    : WIDTH-bit add/sub split into CHUNK-bit slices, one register stage
//            per slice, valid/ready handshake with a single global advance.
// Revision : 1.0
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c1,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic             w_adv;

  logic             w_v_in   [STAGES];
  logic [WIDTH-1:0] w_res_in [STAGES];
  logic [WIDTH-1:0] w_x_in   [STAGES];
  logic [WIDTH-1:0] w_y_in   [STAGES];
  logic             w_c_in   [STAGES];

  logic             r_v_q    [STAGES];
  logic [WIDTH-1:0] r_res_q  [STAGES];
  logic [WIDTH-1:0] r_x_q    [STAGES];
  logic [WIDTH-1:0] r_y_q    [STAGES];
  logic             r_c_q    [STAGES];
  logic             r_cmsb_q [STAGES];

  // Whole pipe moves or holds as one; a stalled output freezes every stage.
  assign w_adv    = ~r_v_q[LAST] | out_ready;
  assign in_ready = w_adv;

  // Subtraction is x + ~y + 1, so the inverted operand enters stage 0 directly.
  assign w_v_in[0]   = in_valid;
  assign w_res_in[0] = '0;
  assign w_x_in[0]   = x;
  assign w_y_in[0]   = sub ? ~y : y;
  assign w_c_in[0]   = sub | c1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BASE = k * CHUNK;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_res_d;
    logic             w_cmsb_d;

    if (k > 0) begin : g_link
      assign w_v_in[k]   = r_v_q[k-1];
      assign w_res_in[k] = r_res_q[k-1];
      assign w_x_in[k]   = r_x_q[k-1];
      assign w_y_in[k]   = r_y_q[k-1];
      assign w_c_in[k]   = r_c_q[k-1];
    end

    assign w_sum = {1'b0, w_x_in[k][BASE +: CHUNK]}
                 + {1'b0, w_y_in[k][BASE +: CHUNK]}
                 + {{CHUNK{1'b0}}, w_c_in[k]};

    always_comb begin
      w_res_d                = w_res_in[k];
      w_res_d[BASE +: CHUNK] = w_sum[CHUNK-1:0];
    end

    // Carry into the slice MSB recovered from its sum bit and operand bits.
    assign w_cmsb_d = w_sum[CHUNK-1] ^ w_x_in[k][BASE+CHUNK-1] ^ w_y_in[k][BASE+CHUNK-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v_q[k]    <= 1'b0;
        r_res_q[k]  <= '0;
        r_x_q[k]    <= '0;
        r_y_q[k]    <= '0;
        r_c_q[k]    <= 1'b0;
        r_cmsb_q[k] <= 1'b0;
      end else if (w_adv) begin
        r_v_q[k]    <= w_v_in[k];
        r_res_q[k]  <= w_res_d;
        r_x_q[k]    <= w_x_in[k];
        r_y_q[k]    <= w_y_in[k];
        r_c_q[k]    <= w_sum[CHUNK];
        r_cmsb_q[k] <= w_cmsb_d;
      end
    end
  end

  assign out_valid = r_v_q[LAST];
  assign z         = r_res_q[LAST];
  assign carry     = r_c_q[LAST];
  assign ovf       = r_cmsb_q[LAST] ^ r_c_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Brief    : Randomised bench for pipelined_adder against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, z;
  logic        c1, sub, carry, ovf;

  logic        a_iv, a_ir, a_ov, a_c1, a_sub, a_carry, a_ovf;
  logic [31:0] a_x, a_y, a_z;
  logic        b_iv, b_ir, b_ov, b_c1, b_sub, b_carry, b_ovf;
  logic [7:0]  b_x, b_y, b_z;

  int total = 0;
  int bad   = 0;
  int recv  = 0;
  logic [33:0] exp_q[$];

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c1(c1), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .carry(carry), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
    .x(a_x), .y(a_y), .c1(a_c1), .sub(a_sub), .out_valid(a_ov),
    .out_ready(1'b1), .z(a_z), .carry(a_carry), .ovf(a_ovf)
  );

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
    .x(b_x), .y(b_y), .c1(b_c1), .sub(b_sub), .out_valid(b_ov),
    .out_ready(1'b1), .z(b_z), .carry(b_carry), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, carry, z} from integer arithmetic on w-bit operands.
  function automatic logic [33:0] model(input int w, input logic [31:0] xv, input logic [31:0] yv,
                                        input logic cv, input logic sv);
    longint mask, half, xa, ya, yb, cin, full, sx, sy, s, zz;
    logic   o, c;
    mask = (64'sd1 <<< w) - 64'sd1;
    half = 64'sd1 <<< (w - 1);
    xa   = longint'(xv) & mask;
    ya   = longint'(yv) & mask;
    yb   = sv ? (~ya & mask) : ya;
    cin  = sv ? 64'sd1 : longint'(cv);
    full = xa + yb + cin;
    zz   = full & mask;
    c    = ((full >>> w) & 64'sd1) != 0;
    sx   = (xa >= half) ? xa - 2 * half : xa;
    sy   = (ya >= half) ? ya - 2 * half : ya;
    s    = sv ? (sx - sy) : (sx + sy + longint'(cv));
    o    = (s >= half) || (s < -half);
    return {o, c, zz[31:0]};
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: record accepted beats, check delivered ones and stall stability.
  initial begin : monitor
    logic [33:0] e;
    logic [17:0] held;
    bit          stall_prev;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stall_hold", {ovf, carry, z}, held);
        if (out_valid && out_ready) begin
          chk("out_has_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("z", z, e[15:0]);
            chk("carry", carry, e[32]);
            chk("ovf", ovf, e[33]);
            recv++;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(16, 32'(x), 32'(y), c1, sub));
        stall_prev = out_valid && !out_ready;
        held       = {ovf, carry, z};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] xv, input logic [15:0] yv, input logic cv, input logic sv);
    int n;
    n        = 0;
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    c1       = cv;
    sub      = sv;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("push_timeout", n, 0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic rand_push();
    push(pick16(), pick16(), 1'($urandom), 1'($urandom));
  endtask

  task automatic latency(output int c);
    @(negedge clk);
    c = 1;
    while (!out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    step();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          lat, r0, l8, l32;
    bit          done;
    logic [33:0] e1;
    logic [15:0] sx;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; c1 = 1'b0; sub = 1'b0; out_ready = 1'b1;
    a_iv = 1'b0; a_x = '0; a_y = '0; a_c1 = 1'b0; a_sub = 1'b0;
    b_iv = 1'b0; b_x = '0; b_y = '0; b_c1 = 1'b0; b_sub = 1'b0;

    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_w32_valid", a_ov, 0);
    chk("rst_w8_valid", b_ov, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_w8_in_ready", b_ir, 1);

    // Unsigned wrap with carry out.
    push(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    latency(lat);
    chk("lat_w16", lat, 4);
    chk("wrap_z", z, 16'h0000);
    chk("wrap_carry", carry, 1);
    chk("wrap_ovf", ovf, 0);
    wait_drain();

    // Subtract: signed overflow, then a borrow.
    push(16'h8000, 16'h0001, 1'b1, 1'b1);
    latency(lat);
    chk("sub_ovf_z", z, 16'h7FFF);
    chk("sub_ovf_carry", carry, 1);
    chk("sub_ovf_ovf", ovf, 1);
    wait_drain();
    push(16'h0000, 16'h0001, 1'b0, 1'b1);
    latency(lat);
    chk("sub_borrow_z", z, 16'hFFFF);
    chk("sub_borrow_carry", carry, 0);
    chk("sub_borrow_ovf", ovf, 0);
    wait_drain();

    // Back-to-back beats must emerge on consecutive cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) rand_push();
      end
      begin
        int n, cnt;
        n   = 0;
        cnt = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 8; i++) begin
          if (out_valid) cnt++;
          @(negedge clk);
        end
        chk("throughput", cnt, 8);
      end
    join
    wait_drain();

    // Random operands with random input gaps.
    r0 = recv;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) step();
      rand_push();
    end
    wait_drain();
    chk("random_count", recv - r0, 200);

    // Fill with out_ready low, stall, then release.
    out_ready = 1'b0;
    r0 = recv;
    sx = pick16();
    e1 = model(16, 32'(sx), 32'h0000_1357, 1'b1, 1'b0);
    push(sx, 16'h1357, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) rand_push();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_z", z, e1[15:0]);
    end
    step();
    out_ready = 1'b1;
    wait_drain();
    chk("stall_count", recv - r0, 4);

    // Random downstream backpressure soak.
    r0   = recv;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 1)) step();
          rand_push();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("soak_count", recv - r0, 150);

    // Asynchronous reset with three beats in flight.
    push(16'h1000, 16'h0234, 1'b0, 1'b0);
    push(16'h2000, 16'h0234, 1'b0, 1'b0);
    push(16'h3000, 16'h0234, 1'b0, 1'b0);
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_z", z, 0);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    r0 = recv;
    push(16'h1234, 16'h1111, 1'b0, 1'b0);
    latency(lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_z", z, 16'h2345);
    wait_drain();
    chk("post_rst_count", recv - r0, 1);

    // Other geometries: 32/8 (four stages) and 8/8 (single stage).
    a_iv = 1'b1; a_x = 32'h7FFF_FFFF; a_y = 32'h0000_0001; a_c1 = 1'b0; a_sub = 1'b0;
    b_iv = 1'b1; b_x = 8'hFF; b_y = 8'h01; b_c1 = 1'b0; b_sub = 1'b0;
    step();
    a_iv = 1'b0;
    b_iv = 1'b0;
    l8  = 0;
    l32 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_ov && l8 == 0) begin
        l8 = c;
        chk("w8_z", b_z, 8'h00);
        chk("w8_carry", b_carry, 1);
        chk("w8_ovf", b_ovf, 0);
      end
      if (a_ov && l32 == 0) begin
        l32 = c;
        chk("w32_z", a_z, 32'h8000_0000);
        chk("w32_carry", a_carry, 0);
        chk("w32_ovf", a_ovf, 1);
      end
    end
    chk("lat_w8", l8, 1);
    chk("lat_w32", l32, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
